scan_ctrl: RTL and testbench

SCAN_CTRL -- requirements
Module: scan_ctrl

---
 rtl/scan_ctrl_pkg.sv | 27 ++
 rtl/scan_ctrl_stall_timer.sv | 62 ++++++
 rtl/scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_ctrl_pkg
// Description : Shared definitions for the scan controller. This package
//               holds the FSM state encoding, the default stall limit and
//               the width of the stall timer.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_ctrl_pkg;

  // Controller states. The 2-bit encoding covers all four states, so no
  // state value is left unused.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  // Number of consecutive stalled RUN cycles that ends a scan with an error.
  localparam int STALL_MAX_DEFAULT = 15;

  // The stall timer is wide enough for the largest legal limit (255).
  localparam int STALL_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/scan_ctrl_stall_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_ctrl_stall_timer
// Description : Stall timer for scan_ctrl. It is a saturating up-counter
//               with an enable, a synchronous clear and a terminal-count
//               flag.
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   i_en      in   count this cycle (one stalled RUN cycle)
//   i_clr     in   clear the count; this input wins over i_en
//   o_expire  out  this enabled cycle takes the count to STALL_MAX
//   o_tc      out  the count currently equals STALL_MAX
// Revision    : 1.0 - initial release
// ============================================================================
module scan_ctrl_stall_timer
  import scan_ctrl_pkg::*;
#(
  parameter int STALL_MAX = STALL_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire,
  output logic o_tc
);

  localparam int                     MAX_M1   = STALL_MAX - 1;
  localparam logic [STALL_CNT_W-1:0] C_MAX    = STALL_MAX[STALL_CNT_W-1:0];
  localparam logic [STALL_CNT_W-1:0] C_MAX_M1 = MAX_M1[STALL_CNT_W-1:0];
  localparam logic [STALL_CNT_W-1:0] C_ONE    = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [STALL_CNT_W-1:0] count_q;
  logic [STALL_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en && (count_q != C_MAX)) begin
      count_d = count_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // o_expire fires in the stalled cycle that makes the count reach the limit.
  // The FSM therefore leaves RUN right after the STALL_MAX-th stalled cycle.
  // After that the count rests at the limit for one cycle. o_tc reports
  // that condition, so the controller can tell in its DONE cycle that the
  // scan ended on a timeout.
  assign o_expire = i_en && !i_clr && (count_q == C_MAX_M1);
  assign o_tc     = (count_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scan_ctrl
// Description : Controller for a two-level (j outer, i inner) index scan
//               that is driven through two external counters. It clears
//               the counters, offers each (i,j) step to a consumer with a
//               valid/ready handshake, and advances the counters on each
//               accepted step. The scan ends on the final carry, on a
//               stall timeout or on an abort.
//   clk, rst           clock, synchronous active-high reset
//   start              begin a scan (sampled in IDLE only)
//   abort              end the current scan (sampled outside IDLE)
//   step_ready         the consumer accepts the current step
//   co_i, co_j         carry-out of the inner and outer counters
//   cnt_i/clr_i        count enable and clear of the inner counter
//   cnt_j/clr_j        count enable and clear of the outer counter
//   step_valid         the current (i,j) is offered to the consumer
//   busy               high whenever the controller is not idle
//   done               one-cycle pulse at scan completion
//   err                with done: the scan ended by stall timeout
// Revision    : 1.0 - initial release
// ============================================================================
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int STALL_MAX = STALL_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic step_ready,
  input  logic co_i,
  input  logic co_j,
  output logic cnt_i,
  output logic clr_i,
  output logic cnt_j,
  output logic clr_j,
  output logic step_valid,
  output logic busy,
  output logic done,
  output logic err
);

  scan_state_t state_q;
  scan_state_t state_d;

  logic run_go;        // in RUN and not aborting: counters may advance
  logic timer_en;
  logic timer_clr;
  logic timer_expire;
  logic timer_tc;

  // --------------------------------------------------------------------------
  // Stall timer. It counts RUN cycles in which the consumer holds off. Any
  // accept, any abort and any cycle outside RUN clears it. Because it is
  // cleared in DONE, every scan starts with the timer at zero.
  // --------------------------------------------------------------------------
  assign timer_en  = (state_q == ST_RUN) && !abort && !step_ready;
  assign timer_clr = (state_q != ST_RUN) || abort || step_ready;

  scan_ctrl_stall_timer #(
    .STALL_MAX (STALL_MAX)
  ) u_stall_timer (
    .clk      (clk),
    .rst      (rst),
    .i_en     (timer_en),
    .i_clr    (timer_clr),
    .o_expire (timer_expire),
    .o_tc     (timer_tc)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Abort is not sampled here, so start wins when both are high.
        if (start) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        // Abort is checked first, so it wins over completion and timeout.
        // co_i can be high only while cnt_i is high, which needs step_ready.
        // So completion and timeout never occur in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (co_i && co_j) begin
          state_d = ST_DONE;
        end else if (timer_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    clr_i      = 1'b0;
    clr_j      = 1'b0;
    step_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    run_go     = 1'b0;
    case (state_q)
      ST_IDLE: begin
      end
      ST_CLEAR: begin
        busy  = 1'b1;
        clr_i = 1'b1;
        clr_j = 1'b1;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort) begin
          // The counters are cleared on the way out. No step is offered,
          // so the step in flight is not counted as accepted.
          clr_i = 1'b1;
          clr_j = 1'b1;
        end else begin
          step_valid = 1'b1;
          run_go     = 1'b1;
        end
      end
      ST_DONE: begin
        busy = 1'b1;
        if (abort) begin
          clr_i = 1'b1;
          clr_j = 1'b1;
        end else begin
          done = 1'b1;
          err  = timer_tc;
        end
      end
      default: begin
      end
    endcase
  end

  // The count enables are kept out of the decode block. The external
  // counters feed co_i back from cnt_i, so this split avoids a
  // combinational path that goes through the same process twice.
  assign cnt_i = run_go && step_ready;
  assign cnt_j = run_go && co_i;

endmodule
`default_nettype wire

// File: tb/tb_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_ctrl
// Description : Directed testbench for scan_ctrl. It attaches two 3-bit
//               index counters, which give a 64-step scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic step_ready;
  logic co_i;
  logic co_j;
  logic cnt_i;
  logic clr_i;
  logic cnt_j;
  logic clr_j;
  logic step_valid;
  logic busy;
  logic done;
  logic err;

  logic [2:0] ci;
  logic [2:0] cj;

  int checks = 0;
  int errors = 0;

  int   n_acc;
  int   n_valid;
  int   order_bad;
  int   clr_in_run;
  int   done_cnt;
  int   err_cnt;
  int   stray_err;
  int   at_done_valid;
  int   timed_out;
  logic abort_ok;

  always #5 clk = ~clk;

  scan_ctrl #(
    .STALL_MAX (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .step_ready (step_ready),
    .co_i       (co_i),
    .co_j       (co_j),
    .cnt_i      (cnt_i),
    .clr_i      (clr_i),
    .cnt_j      (cnt_j),
    .clr_j      (clr_j),
    .step_valid (step_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Attached index counters: synchronous clear, count enable, shared reset.
  always_ff @(posedge clk) begin
    if (rst || clr_i) ci <= 3'd0;
    else if (cnt_i)   ci <= ci + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_j) cj <= 3'd0;
    else if (cnt_j)   cj <= cj + 3'd1;
  end

  assign co_i = cnt_i && (ci == 3'd7);
  assign co_j = cnt_j && (cj == 3'd7);

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int outs();
    return int'({cnt_i, clr_i, cnt_j, clr_j, step_valid, busy, done, err});
  endfunction

  // Apply the inputs for one cycle at the falling edge, then sample after
  // the combinational outputs have settled and before the next rising edge.
  task automatic cyc(input logic s, input logic a, input logic r, input logic rr);
    @(negedge clk);
    start      = s;
    abort      = a;
    step_ready = r;
    rst        = rr;
    #1;
  endtask

  // mode 0: ready always high
  // mode 1: ready 0,1,0,1,... from the first RUN cycle
  // mode 2: ready held low for 15 cycles after the 10th accept
  // mode 3: abort in the cycle that would be accept number abort_at+1
  // mode 4: start pulse while busy; rst in the cycle of the 30th step
  task automatic run_scan(input int mode, input int abort_at, input logic with_abort);
    int   stalled;
    logic r, a, s, rr;
    bit   fin;
    n_acc = 0; n_valid = 0; order_bad = 0; clr_in_run = 0; done_cnt = 0;
    err_cnt = 0; stray_err = 0; at_done_valid = -1; abort_ok = 1'b0;
    stalled = 0; fin = 1'b0;
    cyc(1'b1, with_abort, 1'b1, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("clear_clr_i", clr_i, 1'b1);
    chk1("clear_clr_j", clr_j, 1'b1);
    chk1("clear_busy", busy, 1'b1);
    chk1("clear_valid", step_valid, 1'b0);
    for (int k = 0; k < 400 && !fin; k++) begin
      r = 1'b1; a = 1'b0; s = 1'b0; rr = 1'b0;
      case (mode)
        1: r = (k % 2 == 1);
        2: if (n_acc == 10 && stalled < 15) begin r = 1'b0; stalled++; end
        3: if (n_acc == abort_at) a = 1'b1;
        4: begin
          if (k == 5) s = 1'b1;
          if (n_acc == 29) rr = 1'b1;
        end
        default: ;
      endcase
      cyc(s, a, r, rr);
      if (step_valid) n_valid++;
      if (step_valid && (clr_i || clr_j)) clr_in_run++;
      if (step_valid && step_ready) begin
        if (ci != 3'(n_acc % 8) || cj != 3'((n_acc / 8) % 8)) order_bad++;
        n_acc++;
      end
      if (err && !done) stray_err++;
      if (done) begin
        done_cnt++;
        if (err) err_cnt++;
        at_done_valid = n_valid;
        fin = 1'b1;
      end
      if (a) begin
        abort_ok = clr_i && clr_j && !cnt_i && !cnt_j && !done && !err;
        fin = 1'b1;
      end
      if (rr) fin = 1'b1;
    end
    timed_out = fin ? 0 : 1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; step_ready = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chkn("reset_outputs", outs(), 0);
    chkn("reset_ci", int'(ci), 0);

    // Uninterrupted scan, consumer always ready
    run_scan(0, 0, 1'b0);
    chkn("t1_accepts", n_acc, 64);
    chkn("t1_valid_cycles", n_valid, 64);
    chkn("t1_done", done_cnt, 1);
    chkn("t1_err", err_cnt, 0);
    chkn("t1_order", order_bad, 0);
    chkn("t1_clr_in_run", clr_in_run, 0);
    chkn("t1_timeout", timed_out, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("t1_busy_after_done", busy, 1'b0);
    chk1("t1_done_one_cycle", done, 1'b0);

    // Alternating ready: 64 accepts over 128 RUN cycles
    run_scan(1, 0, 1'b0);
    chkn("t2_accepts", n_acc, 64);
    chkn("t2_run_cycles", at_done_valid, 128);
    chkn("t2_order", order_bad, 0);
    chkn("t2_done", done_cnt, 1);
    chkn("t2_err", err_cnt, 0);

    // Stall timeout after the 10th accept
    run_scan(2, 0, 1'b0);
    chkn("t3_accepts", n_acc, 10);
    chkn("t3_done", done_cnt, 1);
    chkn("t3_err_with_done", err_cnt, 1);
    chkn("t3_run_cycles", at_done_valid, 25);
    chkn("t3_stray_err", stray_err, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("t3_idle_after", busy, 1'b0);

    // Abort at the 20th accept
    run_scan(3, 19, 1'b0);
    chk1("t4_abort_outputs", abort_ok, 1'b1);
    chkn("t4_no_done", done_cnt, 0);
    chkn("t4_accepts", n_acc, 19);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("t4_idle_after", busy, 1'b0);
    chk1("t4_no_late_done", done, 1'b0);

    // Restart from (0,0), with start and abort high together in IDLE
    run_scan(0, 0, 1'b1);
    chkn("t5_accepts", n_acc, 64);
    chkn("t5_order", order_bad, 0);
    chkn("t5_done", done_cnt, 1);
    chkn("t5_err", err_cnt, 0);

    // Abort wins over completion on the final step
    run_scan(3, 63, 1'b0);
    chk1("t6_abort_outputs", abort_ok, 1'b1);
    chkn("t6_no_done", done_cnt, 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk1("t6_idle_after", busy, 1'b0);

    // Start while busy is ignored; reset in the cycle of the 30th step
    run_scan(4, 0, 1'b0);
    chkn("t7_accepts", n_acc, 30);
    chkn("t7_order", order_bad, 0);
    chkn("t7_no_done", done_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chkn("t7_outputs_after_rst", outs(), 0);
    chkn("t7_counters_after_rst", int'({cj, ci}), 0);

    // A full scan after reset
    run_scan(0, 0, 1'b0);
    chkn("t8_accepts", n_acc, 64);
    chkn("t8_order", order_bad, 0);
    chkn("t8_done", done_cnt, 1);
    chkn("t8_timeout", timed_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
